// File: rtl/alu_sched_if.sv
// Request/response bus between requesters and the shared-ALU scheduler.
// Requesters and the response consumer sit on the master side; the scheduler sits on the slave side.
interface alu_sched_if #(
   parameter int NUM_REQ = 4
) ();
   logic [NUM_REQ-1:0]         req_valid;
   logic [2*NUM_REQ-1:0]       req_op;
   logic [36*NUM_REQ-1:0]      req_a;
   logic [36*NUM_REQ-1:0]      req_b;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       resp_valid;
   logic                       resp_ready;
   logic [$clog2(NUM_REQ)-1:0] resp_id;
   logic [35:0]                resp_y;
   logic                       resp_error;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_y, resp_error
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_id, resp_y, resp_error
   );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one 1-cycle ALU among NUM_REQ requesters, one op in flight.
// Result valid 2 edges after accept; requests wait (req_ready low) until the response handshakes.
module alu_sched #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   alu_sched_if.slave       bus,
   output logic [1:0]       alu_op,
   output logic [35:0]      alu_a,
   output logic [35:0]      alu_b,
   input  logic [35:0]      alu_y,
   input  logic             alu_error,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] err_count
);
   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   cand;
   logic              grant_any;
   logic [1:0]        sel_op;
   logic [35:0]       sel_a;
   logic [35:0]       sel_b;

   // Search begins one past the previous winner so every requester gets a turn.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
         if (!grant_any && bus.req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_op = bus.req_op[2*i +: 2];
            sel_a  = bus.req_a[36*i +: 36];
            sel_b  = bus.req_b[36*i +: 36];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = EXEC;
         EXEC:    state_nxt = CAPT;
         CAPT:    state_nxt = RESP;
         RESP:    if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant is gated by reset so nothing looks accepted while the block is held.
   always_comb begin
      bus.req_ready  = '0;
      bus.resp_valid = 1'b0;
      if (!reset && state == IDLE && grant_any)
         bus.req_ready = NUM_REQ'(1) << grant_idx;
      if (state == RESP)
         bus.resp_valid = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_op         <= '0;
         alu_a          <= '0;
         alu_b          <= '0;
         bus.resp_id    <= '0;
         bus.resp_y     <= '0;
         bus.resp_error <= 1'b0;
         op_count       <= '0;
         err_count      <= '0;
         last_grant     <= ID_W'(NUM_REQ - 1);
      end else begin
         if (state == IDLE && grant_any) begin
            alu_op      <= sel_op;
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            bus.resp_id <= grant_idx;
            last_grant  <= grant_idx;
         end
         if (state == CAPT) begin
            bus.resp_y     <= alu_y;
            bus.resp_error <= alu_error;
            op_count       <= op_count + CNT_W'(1);
            if (alu_error && err_count != '1)
               err_count <= err_count + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural 1-cycle registered ALU.
// Counters are narrowed to 4 bits so wrap and saturation are reached in a few dozen operations.
module tb_alu_sched;
   localparam int NR = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    alu_op;
   logic [35:0]   alu_a;
   logic [35:0]   alu_b;
   logic [35:0]   alu_y = '0;
   logic          alu_error = 1'b0;
   logic [CW-1:0] op_count;
   logic [CW-1:0] err_count;

   logic [CW-1:0] exp_ops;
   logic [CW-1:0] exp_errs;
   int            n_checks = 0;
   int            n_errors = 0;

   alu_sched_if #(.NUM_REQ(NR)) bus ();

   alu_sched #(.NUM_REQ(NR), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_y     (alu_y),
      .alu_error (alu_error),
      .op_count  (op_count),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      alu_error <= 1'b0;
      case (alu_op)
         2'd0: alu_y <= alu_a + alu_b;
         2'd1: alu_y <= alu_a - alu_b;
         2'd2: alu_y <= $signed(alu_a) * $signed(alu_b);
         default: begin
            if (alu_b == '0) begin
               alu_y     <= '0;
               alu_error <= 1'b1;
            end else begin
               alu_y <= $signed(alu_a) / $signed(alu_b);
            end
         end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bump(input logic ee);
      exp_ops = exp_ops + CW'(1);
      if (ee && exp_errs != '1) exp_errs = exp_errs + CW'(1);
   endtask

   // Called right after a falling edge with the scheduler idle; returns on a falling edge, idle again.
   task automatic do_op(input int i, input logic [1:0] op, input logic [35:0] a, input logic [35:0] b,
                        input logic [35:0] ey, input logic ee, input int hold,
                        input logic [NR-1:0] pend, input string tag);
      logic [NR-1:0] onehot;
      onehot = NR'(1) << i;
      bus.req_valid = onehot;
      bus.req_op[2*i +: 2] = op;
      bus.req_a[36*i +: 36] = a;
      bus.req_b[36*i +: 36] = b;
      bus.resp_ready = (hold == 0);
      #1 check({tag, ".grant"}, bus.req_ready, onehot);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = '0;
      #1 check({tag, ".exec"}, {bus.resp_valid, bus.req_ready}, 0);
      check({tag, ".drv_a"}, {alu_op, alu_a}, {op, a});
      check({tag, ".drv_b"}, alu_b, b);
      @(negedge clk);
      check({tag, ".capt"}, bus.resp_valid, 0);
      bump(ee);
      bus.req_valid = pend;
      @(negedge clk);
      check({tag, ".resp"}, {bus.resp_valid, bus.resp_id, bus.resp_error}, {1'b1, 2'(i), ee});
      check({tag, ".y"}, bus.resp_y, ey);
      check({tag, ".cnt"}, {op_count, err_count}, {exp_ops, exp_errs});
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         check({tag, ".hold"}, {bus.resp_valid, bus.req_ready, bus.resp_id, bus.resp_error, bus.resp_y},
               {1'b1, {NR{1'b0}}, 2'(i), ee, ey});
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check({tag, ".done"}, bus.resp_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic seen;
      reset          = 1'b1;
      bus.req_valid  = '0;
      bus.req_op     = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b0;
      exp_ops        = '0;
      exp_errs       = '0;

      #2;
      check("rst.flags", {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_error}, 0);
      check("rst.y", bus.resp_y, 0);
      check("rst.alu", {alu_op, alu_a, alu_b[25:0]}, 0);
      check("rst.cnt", {op_count, err_count}, 0);
      bus.req_valid = 4'b0001;
      #1 check("rst.noready", bus.req_ready, 0);
      bus.req_valid = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      do_op(0, 2'd0, 36'd5, 36'hFFFFFFFF9, 36'hFFFFFFFFE, 1'b0, 0, '0, "add");
      do_op(2, 2'd3, 36'd100, 36'd0, 36'd0, 1'b1, 0, '0, "div0");
      do_op(2, 2'd3, 36'hFFFFFFFF7, 36'd2, 36'hFFFFFFFFC, 1'b0, 0, '0, "div");
      do_op(1, 2'd2, 36'hFFFFFFFFD, 36'd7, 36'hFFFFFFFEB, 1'b0, 0, '0, "mul");
      do_op(0, 2'd2, 36'h400000000, 36'd4, 36'd0, 1'b0, 0, '0, "multrunc");
      do_op(3, 2'd1, 36'd10, 36'd25, 36'hFFFFFFFF1, 1'b0, 0, '0, "sub");

      // Last winner was requester 3, so the rotation restarts at 0.
      for (int i = 0; i < NR; i++) begin
         bus.req_op[2*i +: 2]  = 2'd0;
         bus.req_a[36*i +: 36] = 36'(i + 1);
         bus.req_b[36*i +: 36] = 36'd1000;
      end
      bus.req_valid  = '1;
      bus.resp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1 check("rr.grant", bus.req_ready, NR'(1) << (k % NR));
         @(posedge clk);
         repeat (3) @(negedge clk);
         bump(1'b0);
         check("rr.id", {bus.resp_valid, bus.resp_id}, {1'b1, 2'(k % NR)});
         check("rr.y", bus.resp_y, 36'(k % NR + 1001));
         check("rr.cnt", {op_count, err_count}, {exp_ops, exp_errs});
         @(negedge clk);
      end
      bus.req_valid = '0;

      bus.req_op[1:0]  = 2'd0;
      bus.req_a[35:0]  = 36'd20;
      bus.req_b[35:0]  = 36'd22;
      do_op(1, 2'd0, 36'd3, 36'd4, 36'd7, 1'b0, 10, 4'b0001, "bp");
      do_op(0, 2'd0, 36'd20, 36'd22, 36'd42, 1'b0, 0, '0, "pend");

      bus.req_valid       = 4'b0001;
      bus.req_op[1:0]     = 2'd2;
      bus.req_a[35:0]     = 36'd3;
      bus.req_b[35:0]     = 36'd3;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = '0;
      reset = 1'b1;
      exp_ops  = '0;
      exp_errs = '0;
      #1 check("midrst.flags", {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_error}, 0);
      check("midrst.y", bus.resp_y, 0);
      check("midrst.alu", {alu_op, alu_a}, 0);
      check("midrst.alub", alu_b, 0);
      check("midrst.cnt", {op_count, err_count}, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | bus.resp_valid;
      end
      check("midrst.noresp", seen, 0);
      do_op(0, 2'd0, 36'd1, 36'd1, 36'd2, 1'b0, 0, '0, "postrst");
      check("postrst.ops", op_count, 1);

      for (int n = 0; n < 14; n++)
         do_op(0, 2'd3, 36'd7, 36'd0, 36'd0, 1'b1, 0, '0, "lim");
      check("ops.full", op_count, 15);
      do_op(0, 2'd3, 36'd7, 36'd0, 36'd0, 1'b1, 0, '0, "lim");
      check("ops.wrap", op_count, 0);
      check("err.full", err_count, 15);
      do_op(0, 2'd3, 36'd7, 36'd0, 36'd0, 1'b1, 0, '0, "lim");
      check("err.sat", err_count, 15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters sharing one ALU instance (2..8).
REQ-002 Parameter: CNT_W, 16, width of the status counters.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 Port: req_op  input  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]; 0 add, 1 sub, 2 mult, 3 div.
REQ-007 Port: req_a  input  36*NUM_REQ  per-requester signed operand A, slice i = [36i+35:36i].
REQ-008 Port: req_b  input  36*NUM_REQ  per-requester signed operand B, same slicing as req_a.
REQ-009 Port: req_ready  output  NUM_REQ  one-hot accept; bit i high means requester i's operation is taken this cycle.
REQ-010 Port: resp_valid  output  1  result available.
REQ-011 Port: resp_ready  input  1  consumer accepts the result.
REQ-012 Port: resp_id  output  $clog2(NUM_REQ)  index of the requester owning the result.
REQ-013 Port: resp_y  output  36  ALU result.
REQ-014 Port: resp_error  output  1  ALU error flag (divide by zero).
REQ-015 Port: alu_op / alu_a / alu_b  output  2 / 36 / 36  registered drive to the ALU op, A and B inputs.
REQ-016 Port: alu_y / alu_error  input  36 / 1  ALU registered result and error flag; ALU latency is 1 clock.
REQ-017 Port: op_count / err_count  output  CNT_W / CNT_W  completed operations and erroring operations.

Function
REQ-018 The FSM SHALL have four states: IDLE, EXEC, CAPT and RESP; exactly one operation is in flight at any time.
REQ-019 In IDLE with any req_valid high, req_ready SHALL assert combinationally for exactly one requester, chosen round-robin.
- Search starts at last_grant+1 and wraps modulo NUM_REQ.
- req_ready SHALL be all-zero in every other state, and in IDLE when no req_valid is high.
REQ-020 At an accepting edge the block SHALL:
- latch the granted requester's op, A and B into alu_op/alu_a/alu_b;
- latch its index into resp_id and last_grant;
- move to EXEC.
REQ-021 alu_op/alu_a/alu_b SHALL hold their values from the accepting edge until the next accept.
REQ-022 EXEC SHALL last exactly one cycle, then move to CAPT; this is the cycle in which the ALU registers its result.
REQ-023 In CAPT the block SHALL:
- latch alu_y into resp_y and alu_error into resp_error;
- increment op_count, wrapping to 0 after all-ones;
- increment err_count if alu_error is 1, saturating at all-ones;
- move to RESP.
REQ-024 In RESP, resp_valid SHALL be 1, and resp_y/resp_error/resp_id SHALL be stable until handshake.
REQ-025 A handshake (resp_valid && resp_ready) SHALL move the FSM to IDLE; resp_valid SHALL fall on that edge.
REQ-026 Timing: resp_valid SHALL rise on the 2nd rising edge after the accepting edge; minimum throughput is one operation per 4 cycles.
REQ-027 Backpressure: while in RESP, requests SHALL NOT be accepted; req_valid held high with req_ready low is legal and SHALL NOT be lost.
REQ-028 resp_ready is don't-care outside RESP.
REQ-029 The block SHALL NOT reinterpret ALU results: Y and error pass through unmodified, including mult truncation and div-by-zero Y=0, error=1.

Reset
REQ-030 On reset assertion, independent of clk, the block SHALL immediately set:
- state to IDLE and req_ready to 0;
- resp_valid, resp_y, resp_error and resp_id to 0;
- alu_op, alu_a and alu_b to 0;
- op_count and err_count to 0;
- last_grant to NUM_REQ-1, so requester 0 wins first.
REQ-031 Reset during EXEC, CAPT or RESP SHALL discard the in-flight operation with no response; counters are not incremented.
REQ-032 After deassertion the first accept SHALL occur no earlier than the first rising edge with reset low.

Verification
REQ-033 Single add: req0 op=0, A=5, B=-7, resp_ready=1 -> req_ready[0] for 1 cycle; resp_valid 2 edges later with resp_id=0, resp_y=-2 (36-bit), resp_error=0; op_count=1.
REQ-034 Div by zero: req2 op=3, A=100, B=0 -> resp_y=0, resp_error=1, err_count=1; following req2 op=3, A=-9, B=2 -> resp_y=-4, resp_error=0.
REQ-035 Fairness: all four req_valid held high, resp_ready=1, for 8 operations -> grant order 0,1,2,3,0,1,2,3; each resp_id matches its grant.
REQ-036 Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp fields stable, req_ready stays 0, no second accept; resp_ready=1 -> IDLE next edge, then the pending request is accepted.
REQ-037 Reset mid-op: assert reset during EXEC of a mult -> all outputs 0 immediately, no resp_valid afterwards; after release req0 add 1+1 -> resp_y=2, op_count=1.
REQ-038 Counter limits: preload or run op_count to 0xFFFF -> next completion wraps it to 0; err_count at 0xFFFF stays 0xFFFF on a further div-by-zero.
